// File: rtl/regfile_write_arbiter.sv
// Single write-port owner for the 8x16 register file: zero-fills r1..r7 after reset,
// then round-robins the port between the ALU (A) and load (B) writeback requesters.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_inaddr,
    output logic [DATA_WIDTH-1:0] rf_in,
    output logic                  init_done,
    output logic [CNT_WIDTH-1:0]  wr_count
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic                  prio;
    logic                  grant_a, grant_b, accept;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_data;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_INIT;
        else       state <= state_next;
    end

    // prio: 0 favours A, 1 favours B when both requesters are valid
    always_comb begin
        state_next = state;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        case (state)
            ST_INIT: begin
                if (&fill_cnt) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    if (a_valid && (!b_valid || !prio)) grant_a = 1'b1;
                    else if (b_valid)                   grant_b = 1'b1;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign accept   = grant_a | grant_b;
    assign acc_addr = grant_a ? a_addr : b_addr;
    assign acc_data = grant_a ? a_data : b_data;

    // r0 writes are accepted but never reach the register file or the counter
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_cnt  <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            prio      <= 1'b0;
            rf_write  <= 1'b0;
            rf_inaddr <= '0;
            rf_in     <= '0;
            init_done <= 1'b0;
            wr_count  <= '0;
        end else if (state == ST_INIT) begin
            rf_write  <= 1'b1;
            rf_inaddr <= fill_cnt;
            rf_in     <= '0;
            fill_cnt  <= fill_cnt + 1'b1;
            if (&fill_cnt) init_done <= 1'b1;
        end else if (accept) begin
            rf_inaddr <= acc_addr;
            rf_in     <= acc_data;
            rf_write  <= (acc_addr != '0);
            if (acc_addr != '0) wr_count <= wr_count + 1'b1;
            prio      <= grant_a;
        end else begin
            rf_write  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed + random bench for regfile_write_arbiter, checked against a
// rule-level reference model of the zero-fill and round-robin arbitration.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset, stall;
    logic        a_valid, b_valid;
    logic [2:0]  a_addr, b_addr;
    logic [15:0] a_data, b_data;
    logic        a_ready, b_ready, rf_write, init_done;
    logic [2:0]  rf_inaddr;
    logic [15:0] rf_in, wr_count;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_done;
    int m_next_fill;
    int m_prio;      // 0 = A, 1 = B
    int m_count;
    bit m_write;
    int m_addr;
    int m_data;

    regfile_write_arbiter dut (
        .clk(clk), .reset(reset), .stall(stall),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_write(rf_write), .rf_inaddr(rf_inaddr), .rf_in(rf_in),
        .init_done(init_done), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at negedge, check readys, clock, then check registered outputs
    task automatic applyStimulus(input bit rst, input bit stl,
                                 input bit av, input int aa, input int ad,
                                 input bit bv, input int ba, input int bd);
        bit ea, eb;
        @(negedge clk);
        reset = rst; stall = stl;
        a_valid = av; a_addr = aa[2:0]; a_data = ad[15:0];
        b_valid = bv; b_addr = ba[2:0]; b_data = bd[15:0];
        #1;
        ea = 0; eb = 0;
        if (m_done && !stl) begin
            if (av && bv) begin
                if (m_prio == 0) ea = 1; else eb = 1;
            end else begin
                ea = av; eb = bv;
            end
        end
        checkOutput("a_ready", {31'd0, a_ready}, {31'd0, ea});
        checkOutput("b_ready", {31'd0, b_ready}, {31'd0, eb});
        @(posedge clk);
        if (rst) begin
            m_done = 0; m_next_fill = 1; m_prio = 0; m_count = 0;
            m_write = 0; m_addr = 0; m_data = 0;
        end else if (!m_done) begin
            m_write = 1; m_addr = m_next_fill; m_data = 0;
            if (m_next_fill == 7) m_done = 1;
            m_next_fill++;
        end else if (ea || eb) begin
            m_addr  = ea ? (aa & 7) : (ba & 7);
            m_data  = ea ? (ad & 16'hFFFF) : (bd & 16'hFFFF);
            m_write = (m_addr != 0);
            if (m_addr != 0) m_count = (m_count + 1) % 65536;
            m_prio  = ea ? 1 : 0;
        end else begin
            m_write = 0;
        end
        #1;
        checkOutput("rf_write",  {31'd0, rf_write},  {31'd0, m_write});
        checkOutput("rf_inaddr", {29'd0, rf_inaddr}, m_addr);
        checkOutput("rf_in",     {16'd0, rf_in},     m_data);
        checkOutput("init_done", {31'd0, init_done}, {31'd0, m_done});
        checkOutput("wr_count",  {16'd0, wr_count},  m_count);
    endtask

    initial begin
        reset = 1; stall = 0; a_valid = 0; b_valid = 0;
        a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
        m_done = 0; m_next_fill = 1; m_prio = 0; m_count = 0;
        m_write = 0; m_addr = 0; m_data = 0;

        // reset, then zero-fill with A requesting throughout (must not be granted)
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (7) applyStimulus(0, 0, 1, 5, 16'h5555, 0, 0, 0);
        applyStimulus(0, 0, 1, 3, 16'hBEEF, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 4, 16'h1234);
        repeat (4) applyStimulus(0, 0, 1, 1, 16'h0011, 1, 2, 16'h0022);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 16'hFFFF);
        applyStimulus(0, 0, 0, 0, 0, 1, 6, 16'h6666);
        repeat (3) applyStimulus(0, 1, 1, 1, 16'h0011, 1, 2, 16'h0022);
        repeat (2) applyStimulus(0, 0, 1, 1, 16'h0011, 1, 2, 16'h0022);
        // reset during a live accept, then the fill must repeat
        applyStimulus(1, 0, 1, 5, 16'hAAAA, 1, 6, 16'hBBBB);
        repeat (8) applyStimulus(0, 0, 1, 5, 16'hAAAA, 1, 6, 16'hBBBB);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
                          $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 65535),
                          $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 65535));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
